// File: rtl/element_delay_sequencer.sv
// element_delay_sequencer: runs per-element increment calculations and streams saturated +n/-n delay pairs
module element_delay_sequencer #(
  parameter int DW_INTEGER = 18,
  parameter int DW_FRACTION = 6,
  parameter int ANGLE_DW = 8,
  parameter int DW_INPUT = 8,
  parameter int NUM_ELEMENTS = 32,
  localparam int TW = DW_INTEGER + DW_FRACTION + 1,
  localparam int IDX_W = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [DW_INPUT-1:0] r_0,
  input  logic [ANGLE_DW-1:0] angle,
  output logic [DW_INPUT-1:0] calc_r_0,
  output logic [ANGLE_DW-1:0] calc_angle,
  output logic                calc_initiate,
  output logic                calc_ack,
  input  logic                calc_ready,
  input  logic [TW-1:0]       calc_term_pos,
  input  logic [TW-1:0]       calc_term_neg,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IDX_W-1:0]    out_index,
  output logic [TW-1:0]       out_delay_pos,
  output logic [TW-1:0]       out_delay_neg,
  output logic                busy,
  output logic                done,
  output logic                overflow
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACK, OUTPUT, DRAIN} state_t;
  localparam logic [TW-1:0] sat_max = {1'b0, {(TW-1){1'b1}}};
  localparam logic [TW-1:0] sat_min = {1'b1, {(TW-1){1'b0}}};
  state_t state;
  logic [TW:0] sum_pos, sum_neg;
  logic ovf_pos, ovf_neg, last;
  logic [TW-1:0] sat_pos, sat_neg;
  assign sum_pos = {out_delay_pos[TW-1], out_delay_pos} + {calc_term_pos[TW-1], calc_term_pos};
  assign sum_neg = {out_delay_neg[TW-1], out_delay_neg} + {calc_term_neg[TW-1], calc_term_neg};
  assign ovf_pos = sum_pos[TW] ^ sum_pos[TW-1];
  assign ovf_neg = sum_neg[TW] ^ sum_neg[TW-1];
  assign sat_pos = ovf_pos ? (sum_pos[TW] ? sat_min : sat_max) : sum_pos[TW-1:0];
  assign sat_neg = ovf_neg ? (sum_neg[TW] ? sat_min : sat_max) : sum_neg[TW-1:0];
  assign last = out_index == IDX_W'(NUM_ELEMENTS - 1);
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      calc_r_0 <= '0;
      calc_angle <= '0;
      calc_initiate <= 1'b0;
      calc_ack <= 1'b0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_delay_pos <= '0;
      out_delay_neg <= '0;
      done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      calc_initiate <= 1'b0;
      calc_ack <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start && !abort) begin
          calc_r_0 <= r_0;
          calc_angle <= angle;
          out_delay_pos <= TW'({r_0, {DW_FRACTION{1'b0}}});
          out_delay_neg <= TW'({r_0, {DW_FRACTION{1'b0}}});
          out_index <= '0;
          overflow <= 1'b0;
          calc_initiate <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: state <= abort ? DRAIN : WAIT;
        WAIT: if (abort) state <= DRAIN;
        else if (calc_ready) begin
          calc_ack <= 1'b1;
          state <= ACK;
        end
        ACK: if (abort) state <= IDLE;
        else begin
          out_delay_pos <= sat_pos;
          out_delay_neg <= sat_neg;
          overflow <= overflow | ovf_pos | ovf_neg;
          out_valid <= 1'b1;
          state <= OUTPUT;
        end
        OUTPUT: if (abort) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end else if (out_ready) begin
          out_valid <= 1'b0;
          done <= last;
          calc_initiate <= !last;
          out_index <= last ? out_index : out_index + IDX_W'(1);
          state <= last ? IDLE : ISSUE;
        end
        DRAIN: if (calc_ready) begin
          calc_ack <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
